// File: rtl/hopfield_pkg.sv
// Shared definitions for the Hopfield network sequencer.
// Optional feature macro: HOPFIELD_SEQ_RELAX_EN (adds the post-training RELAX phase).
package hopfield_pkg;

  localparam int NUM_NEURONS = 7;
  localparam int PATTERN_W   = 4;

  localparam logic OP_TRAIN  = 1'b0;
  localparam logic OP_RECALL = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_TRAIN  = 3'd1,
    S_CUE    = 3'd2,
    S_SETTLE = 3'd3,
    S_WINDOW = 3'd4,
    S_RESULT = 3'd5
`ifdef HOPFIELD_SEQ_RELAX_EN
    , S_RELAX = 3'd6
`endif
  } state_t;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hopfield_sequencer_spike_counter_bank.sv
// Seven saturating spike counters with synchronous clear/enable and a
// threshold compare. The pattern output is taken from the counts as they
// will be after the current cycle's spikes, so the last window cycle is
// included when the top registers the result at the window's final edge.
module spike_counter_bank
  import hopfield_pkg::*;
#(
  parameter int CNT_W        = 8,
  parameter int SPIKE_THRESH = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clr,
  input  logic                   en,
  input  logic [NUM_NEURONS-1:0] spikes,
  output logic [NUM_NEURONS-1:0] pattern
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] count      [NUM_NEURONS];
  logic [CNT_W-1:0] count_next [NUM_NEURONS];

  // Saturating increment and threshold compare on the would-be counts.
  always_comb begin
    for (int k = 0; k < NUM_NEURONS; k++) begin
      if (en && spikes[k] && (count[k] != CNT_MAX)) begin
        count_next[k] = count[k] + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        count_next[k] = count[k];
      end
      pattern[k] = (32'(count_next[k]) >= $unsigned(SPIKE_THRESH));
    end
  end

  // Counter registers: cleared by reset or clr, otherwise take the next count.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_NEURONS; k++) begin
      if (reset || clr) begin
        count[k] <= {CNT_W{1'b0}};
      end else begin
        count[k] <= count_next[k];
      end
    end
  end

endmodule

// File: rtl/hopfield_sequencer.sv
// Train/recall sequencer for the 7-neuron Hopfield spiking network.
// Optional feature macro: HOPFIELD_SEQ_RELAX_EN (RELAX phase after TRAIN).
// All outputs are registered from the next-state values so they change on
// the same edge as the state they describe.
module hopfield_sequencer
  import hopfield_pkg::*;
#(
  parameter int TRAIN_CYCLES  = 64,
  parameter int CUE_CYCLES    = 4,
  parameter int SETTLE_CYCLES = 32,
  parameter int WINDOW_CYCLES = 64,
  parameter int SPIKE_THRESH  = 2,
  parameter int CNT_W         = 8,
  parameter int RELAX_CYCLES  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_op,
  input  logic [PATTERN_W-1:0]   cmd_pattern,
  input  logic [NUM_NEURONS-1:0] spikes,
  output logic                   learning_enable,
  output logic [PATTERN_W-1:0]   pattern_input,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic [NUM_NEURONS-1:0] result_pattern,
  output logic                   busy
);

  // Phase counter is wide enough for every phase length, including RELAX.
  localparam int MAX_PHASE = max_int(max_int(max_int(TRAIN_CYCLES, CUE_CYCLES),
                                             max_int(SETTLE_CYCLES, WINDOW_CYCLES)),
                                     RELAX_CYCLES);
  localparam int PH_W = (MAX_PHASE > 1) ? $clog2(MAX_PHASE) : 1;

  localparam logic [PH_W-1:0] PH_ZERO = {PH_W{1'b0}};
  localparam logic [PH_W-1:0] PH_ONE  = {{(PH_W-1){1'b0}}, 1'b1};

  state_t                 state, state_next;
  logic [PH_W-1:0]        phase, phase_next;
  logic [PATTERN_W-1:0]   pat_latch, pat_next;
  logic                   cnt_clr, cnt_en, load_result;
  logic [NUM_NEURONS-1:0] bank_pattern;

  spike_counter_bank #(
    .CNT_W        (CNT_W),
    .SPIKE_THRESH (SPIKE_THRESH)
  ) u_bank (
    .clk     (clk),
    .reset   (reset),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .spikes  (spikes),
    .pattern (bank_pattern)
  );

  // Next-state, phase counter and counter-bank control.
  always_comb begin
    state_next  = state;
    phase_next  = phase;
    pat_next    = pat_latch;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
    load_result = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          pat_next = cmd_pattern;
          if (cmd_op == OP_RECALL) begin
            state_next = S_CUE;
            phase_next = PH_W'(CUE_CYCLES - 1);
          end else begin
            state_next = S_TRAIN;
            phase_next = PH_W'(TRAIN_CYCLES - 1);
          end
        end else begin
          state_next = S_IDLE;
        end
      end
      S_TRAIN: begin
        if (phase == PH_ZERO) begin
`ifdef HOPFIELD_SEQ_RELAX_EN
          state_next = S_RELAX;
          phase_next = PH_W'(RELAX_CYCLES - 1);
`else
          state_next = S_IDLE;
`endif
        end else begin
          phase_next = phase - PH_ONE;
        end
      end
      S_CUE: begin
        if (phase == PH_ZERO) begin
          state_next = S_SETTLE;
          phase_next = PH_W'(SETTLE_CYCLES - 1);
        end else begin
          phase_next = phase - PH_ONE;
        end
      end
      S_SETTLE: begin
        if (phase == PH_ZERO) begin
          state_next = S_WINDOW;
          phase_next = PH_W'(WINDOW_CYCLES - 1);
          cnt_clr    = 1'b1;
        end else begin
          phase_next = phase - PH_ONE;
        end
      end
      S_WINDOW: begin
        cnt_en = 1'b1;
        if (phase == PH_ZERO) begin
          state_next  = S_RESULT;
          load_result = 1'b1;
        end else begin
          phase_next = phase - PH_ONE;
        end
      end
      S_RESULT: begin
        if (result_ready) begin
          state_next = S_IDLE;
        end else begin
          state_next = S_RESULT;
        end
      end
`ifdef HOPFIELD_SEQ_RELAX_EN
      S_RELAX: begin
        if (phase == PH_ZERO) begin
          state_next = S_IDLE;
        end else begin
          phase_next = phase - PH_ONE;
        end
      end
`endif
      default: begin
        state_next = S_IDLE;
        phase_next = PH_ZERO;
      end
    endcase
  end

  // State, latches and registered outputs derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      phase           <= PH_ZERO;
      pat_latch       <= {PATTERN_W{1'b0}};
      cmd_ready       <= 1'b1;
      busy            <= 1'b0;
      learning_enable <= 1'b0;
      pattern_input   <= {PATTERN_W{1'b0}};
      result_valid    <= 1'b0;
      result_pattern  <= {NUM_NEURONS{1'b0}};
    end else begin
      state           <= state_next;
      phase           <= phase_next;
      pat_latch       <= pat_next;
      cmd_ready       <= (state_next == S_IDLE);
      busy            <= (state_next != S_IDLE);
      learning_enable <= (state_next == S_TRAIN) || (state_next == S_CUE);
      pattern_input   <= ((state_next == S_TRAIN) || (state_next == S_CUE)) ?
                         pat_next : {PATTERN_W{1'b0}};
      result_valid    <= (state_next == S_RESULT);
      if (load_result) begin
        result_pattern <= bank_pattern;
      end else begin
        result_pattern <= result_pattern;
      end
    end
  end

endmodule

// File: tb/tb_hopfield_sequencer.sv
// Self-checking bench for hopfield_sequencer: directed and randomized
// train/recall episodes checked against a cycle-count/spike-sum model.
module tb_hopfield_sequencer;

  localparam int TR = 8;
  localparam int CU = 2;
  localparam int SE = 3;
  localparam int WI = 5;
  localparam int TH = 2;
  localparam int RL = 4;
`ifdef HOPFIELD_SEQ_RELAX_EN
  localparam int RLX = RL;
`else
  localparam int RLX = 0;
`endif
  // Saturation instance parameters
  localparam int S_WI = 10;
  localparam int S_TH = 3;
  localparam int S_MAX = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_op = 1'b0;
  logic [3:0] cmd_pattern = 4'd0, pattern_input;
  logic [6:0] spikes = 7'd0, result_pattern;
  logic       learning_enable, result_valid, result_ready = 1'b0, busy;

  logic       s_cmd_valid = 1'b0, s_cmd_ready, s_cmd_op = 1'b1;
  logic [3:0] s_cmd_pattern = 4'd0, s_pattern_input;
  logic [6:0] s_spikes = 7'd0, s_result_pattern;
  logic       s_learning_enable, s_result_valid, s_result_ready = 1'b0, s_busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hopfield_sequencer #(
    .TRAIN_CYCLES(TR), .CUE_CYCLES(CU), .SETTLE_CYCLES(SE), .WINDOW_CYCLES(WI),
    .SPIKE_THRESH(TH), .CNT_W(8), .RELAX_CYCLES(RL)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_pattern(cmd_pattern), .spikes(spikes),
    .learning_enable(learning_enable), .pattern_input(pattern_input),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_pattern(result_pattern), .busy(busy)
  );

  hopfield_sequencer #(
    .TRAIN_CYCLES(TR), .CUE_CYCLES(CU), .SETTLE_CYCLES(SE), .WINDOW_CYCLES(S_WI),
    .SPIKE_THRESH(S_TH), .CNT_W(2), .RELAX_CYCLES(RL)
  ) dut_sat (
    .clk(clk), .reset(reset), .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready),
    .cmd_op(s_cmd_op), .cmd_pattern(s_cmd_pattern), .spikes(s_spikes),
    .learning_enable(s_learning_enable), .pattern_input(s_pattern_input),
    .result_valid(s_result_valid), .result_ready(s_result_ready),
    .result_pattern(s_result_pattern), .busy(s_busy)
  );

  // Advance one cycle; sample point is just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] obs, exp_v;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
    obs = {cmd_ready, busy, learning_enable, pattern_input, result_valid};
    n_checks++;
    if (obs !== exp_v || result_pattern !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_main: got %b/%b want %b/0000000", obs, result_pattern, exp_v);
    end
    obs = {s_cmd_ready, s_busy, s_learning_enable, s_pattern_input, s_result_valid};
    n_checks++;
    if (obs !== exp_v || s_result_pattern !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_sat: got %b/%b want %b/0000000", obs, s_result_pattern, exp_v);
    end
  endtask

  task automatic test_train(input logic [3:0] pat);
    logic [7:0] obs, exp_v;
    cmd_op = 1'b0;
    cmd_pattern = pat;
    cmd_valid = 1'b1;
    tick();
    for (int c = 1; c <= TR + RLX; c++) begin
      if (c <= TR) exp_v = {1'b0, 1'b1, 1'b1, pat, 1'b0};
      else         exp_v = {1'b0, 1'b1, 1'b0, 4'b0000, 1'b0};
      obs = {cmd_ready, busy, learning_enable, pattern_input, result_valid};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL train_cycle%0d: got %b want %b", c, obs, exp_v);
      end
      cmd_valid = 1'($urandom_range(1, 0));
      cmd_op = 1'($urandom_range(1, 0));
      cmd_pattern = 4'($urandom);
      tick();
    end
    cmd_valid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      exp_v = {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
      obs = {cmd_ready, busy, learning_enable, pattern_input, result_valid};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL train_idle%0d: got %b want %b", c, obs, exp_v);
      end
      tick();
    end
  endtask

  // mode 0: random spikes; 1: ones in settle/cue, 0000101 in window;
  // 2: ones outside the window, zero inside.
  task automatic test_recall(input logic [3:0] pat, input int mode, input int hold);
    logic [7:0] obs, exp_v;
    logic [6:0] exp_pat;
    int cnt [7];
    for (int k = 0; k < 7; k++) cnt[k] = 0;
    cmd_op = 1'b1;
    cmd_pattern = pat;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int c = 1; c <= CU + SE + WI; c++) begin
      if (mode == 1)      spikes = (c > CU + SE) ? 7'b0000101 : 7'b1111111;
      else if (mode == 2) spikes = (c > CU + SE) ? 7'b0000000 : 7'b1111111;
      else                spikes = 7'($urandom);
      if (c > CU + SE) begin
        for (int k = 0; k < 7; k++) if (spikes[k]) cnt[k]++;
      end
      exp_v = {1'b0, 1'b1, (c <= CU) ? 1'b1 : 1'b0, (c <= CU) ? pat : 4'b0000, 1'b0};
      obs = {cmd_ready, busy, learning_enable, pattern_input, result_valid};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL recall_cycle%0d: got %b want %b", c, obs, exp_v);
      end
      cmd_valid = 1'($urandom_range(1, 0));
      cmd_op = 1'($urandom_range(1, 0));
      tick();
    end
    spikes = 7'($urandom);
    for (int k = 0; k < 7; k++) exp_pat[k] = (((cnt[k] > 255) ? 255 : cnt[k]) >= TH);
    for (int h = 0; h <= hold; h++) begin
      exp_v = {1'b0, 1'b1, 1'b0, 4'b0000, 1'b1};
      obs = {cmd_ready, busy, learning_enable, pattern_input, result_valid};
      n_checks++;
      if (obs !== exp_v || result_pattern !== exp_pat) begin
        n_fail++;
        $display("FAIL result_hold%0d: got %b/%b want %b/%b", h, obs, result_pattern, exp_v, exp_pat);
      end
      cmd_valid = 1'b1;
      cmd_op = 1'($urandom_range(1, 0));
      result_ready = (h == hold);
      tick();
    end
    cmd_valid = 1'b0;
    result_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      exp_v = {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
      obs = {cmd_ready, busy, learning_enable, pattern_input, result_valid};
      n_checks++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL recall_idle%0d: got %b want %b", c, obs, exp_v);
      end
      tick();
    end
  endtask

  task automatic test_reset_in_window();
    logic [7:0] obs, exp_v;
    cmd_op = 1'b1;
    cmd_pattern = 4'b0110;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    spikes = 7'b1111111;
    for (int c = 1; c <= CU + SE + 1; c++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_v = {1'b1, 1'b0, 1'b0, 4'b0000, 1'b0};
    obs = {cmd_ready, busy, learning_enable, pattern_input, result_valid};
    n_checks++;
    if (obs !== exp_v || result_pattern !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_window: got %b/%b want %b/0000000", obs, result_pattern, exp_v);
    end
    test_recall(4'b0101, 2, 0);
  endtask

  task automatic test_saturation();
    int cnt [7];
    logic [6:0] exp_pat;
    for (int k = 0; k < 7; k++) cnt[k] = 0;
    s_cmd_op = 1'b1;
    s_cmd_pattern = 4'b1001;
    s_cmd_valid = 1'b1;
    tick();
    s_cmd_valid = 1'b0;
    for (int c = 1; c <= CU + SE + S_WI; c++) begin
      s_spikes = {6'($urandom), 1'b1};
      if (c > CU + SE) begin
        for (int k = 0; k < 7; k++) if (s_spikes[k]) cnt[k]++;
      end
      tick();
    end
    for (int k = 0; k < 7; k++) exp_pat[k] = (((cnt[k] > S_MAX) ? S_MAX : cnt[k]) >= S_TH);
    n_checks++;
    if (s_result_valid !== 1'b1 || s_result_pattern !== exp_pat) begin
      n_fail++;
      $display("FAIL saturation: got v=%b p=%b want v=1 p=%b", s_result_valid, s_result_pattern, exp_pat);
    end
    s_result_ready = 1'b1;
    tick();
    s_result_ready = 1'b0;
    n_checks++;
    if (s_cmd_ready !== 1'b1 || s_result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL saturation_done: got ready=%b valid=%b want 1/0", s_cmd_ready, s_result_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(1, 0) == 0) test_train(4'($urandom));
      else test_recall(4'($urandom), 0, int'($urandom_range(3, 0)));
    end
  endtask

  initial begin
    test_reset();
    test_train(4'b1010);
    test_recall(4'b0011, 1, 0);
    test_recall(4'b1100, 0, 6);
    test_reset_in_window();
    test_saturation();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hopfield_sequencer.md
# hopfield_sequencer

Controller that sequences the 7-neuron Hopfield spiking network through training and recall episodes. It accepts train/recall commands over a valid/ready handshake and drives the network's `learning_enable` and `pattern_input` pins with exact phase timing. During recall it counts spikes per neuron over a fixed window and returns a thresholded 7-bit recalled pattern over a second valid/ready handshake. It sits between the host/test logic and `hopfield_network`.

## Interface
- `TRAIN_CYCLES`, default 64: cycles `learning_enable` and the pattern are held during training (≥1).
- `CUE_CYCLES`, default 4: cycles the recall cue is injected (≥1).
- `SETTLE_CYCLES`, default 32: quiet cycles before counting (≥1).
- `WINDOW_CYCLES`, default 64: spike-count window length (≥1).
- `SPIKE_THRESH`, default 2: minimum count for a result bit to be 1 (≥1).
- `CNT_W`, default 8: spike counter width, saturating.
- `RELAX_CYCLES`, default 16: post-training quiet period (used only with the macro).

Ports:
- `clk`, in, 1: single clock, rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `cmd_valid`, in, 1: command offered.
- `cmd_ready`, out, 1: sequencer can accept a command.
- `cmd_op`, in, 1: 0 = train, 1 = recall.
- `cmd_pattern`, in, 4: pattern to train or cue.
- `spikes`, in, 7: spike outputs of the network.
- `learning_enable`, out, 1: to the network.
- `pattern_input`, out, 4: to the network.
- `result_valid`, out, 1: recall result available.
- `result_ready`, in, 1: consumer accepts result.
- `result_pattern`, out, 7: bit k = 1 iff neuron k count ≥ `SPIKE_THRESH`.
- `busy`, out, 1: state ≠ IDLE.

## Operation
- States: IDLE, TRAIN, CUE, SETTLE, WINDOW, RESULT, plus RELAX when the macro is defined.
- IDLE:
  - `cmd_ready`=1.
  - When `cmd_valid` is high, latch `cmd_op`/`cmd_pattern` and go to TRAIN (op 0) or CUE (op 1).
- TRAIN:
  - `learning_enable`=1 and `pattern_input`=latched pattern for exactly `TRAIN_CYCLES` cycles.
  - Then go to IDLE, or to RELAX if the macro is defined.
- CUE:
  - `learning_enable`=1 and `pattern_input`=latched pattern for exactly `CUE_CYCLES` cycles, then SETTLE.
  - The network only injects input current while learning is enabled, so a brief weight update during the cue is accepted.
- SETTLE:
  - `learning_enable`=0, `pattern_input`=0 for `SETTLE_CYCLES` cycles.
  - Spikes are ignored.
  - All 7 counters are cleared on the last SETTLE cycle.
- WINDOW:
  - Outputs as in SETTLE for `WINDOW_CYCLES` cycles.
  - Each cycle, counter k increments when `spikes[k]` is high.
  - Counters saturate at 2^`CNT_W`−1 and never wrap.
- RESULT:
  - `result_pattern` is computed from the counters when the window ends and registered on entry.
  - `result_valid`=1, held stable until `result_ready`, then IDLE.
- Phase counter:
  - One shared down-counter, width sized for the largest cycle parameter.
  - Loaded with N−1 on phase entry; the phase exits when the counter reads 0.
- `cmd_valid` outside IDLE is ignored: no latch, no queue.
- A reset in any state returns to IDLE and clears the counters, latches and all outputs. Network weights are not touched.

## Timing
- All outputs are registered.
- Reset values: `cmd_ready`=1, `learning_enable`=0, `pattern_input`=0, `result_valid`=0, `result_pattern`=0, `busy`=0.
- Command accepted at edge t:
  - `cmd_ready`=0 and `learning_enable`=1 from cycle t+1.
  - Train: `learning_enable` is high for cycles t+1 … t+`TRAIN_CYCLES`; `cmd_ready`=1 at t+`TRAIN_CYCLES`+1 (no RELAX).
  - Recall: `result_valid` rises at cycle t+`CUE_CYCLES`+`SETTLE_CYCLES`+`WINDOW_CYCLES`+1.
- Spikes are counted from the first to the last WINDOW cycle inclusive.
- `result_valid` and `result_ready` high in the same cycle: handshake completes; IDLE and `cmd_ready`=1 the next cycle.
- There is no back-to-back acceptance in the handshake cycle.

## Configuration
- `HOPFIELD_SEQ_RELAX_EN`:
  - Defined: TRAIN is followed by RELAX for `RELAX_CYCLES` cycles (`learning_enable`=0, `pattern_input`=0, `busy`=1), then IDLE. This lets network membrane state decay before the next command.
  - Undefined: the RELAX state and `RELAX_CYCLES` logic are absent; TRAIN returns directly to IDLE.

## Structure
- Shared package `hopfield_pkg`:
  - State enum encoding.
  - `NUM_NEURONS`=7 and `PATTERN_W`=4.
  - Opcode constants `OP_TRAIN`/`OP_RECALL`.
- One sub-module, `spike_counter_bank`: 7 saturating `CNT_W` counters with clear/enable and threshold compare, producing the 7-bit pattern.
- FSM, phase counter and handshakes live in the top module.

## Test plan
Use TRAIN=8, CUE=2, SETTLE=3, WINDOW=5, THRESH=2 unless noted.
- Train op, pattern 4'b1010:
  - `learning_enable`=1 and `pattern_input`=4'b1010 for exactly 8 cycles.
  - `cmd_ready` returns 1 on cycle 9.
- Recall, cue 4'b0011; `spikes` held 7'b0000101 through WINDOW and 7'b1111111 during SETTLE:
  - `result_pattern`=7'b0000101.
  - `result_valid` at cycle 11.
- Saturation, `CNT_W`=2, WINDOW=10, `spikes[0]` always high, THRESH=3:
  - Counter stops at 3; bit 0 = 1 with no wrap to 0.
- Result backpressure: `result_ready`=0 for 6 cycles, then 1:
  - `result_valid`/`result_pattern` stable throughout.
  - IDLE next cycle; `cmd_valid` during RESULT is ignored.
- Reset asserted in the 2nd WINDOW cycle:
  - Next cycle shows all reset values.
  - A fresh recall gives a result unaffected by pre-reset counts.
- With `HOPFIELD_SEQ_RELAX_EN`, RELAX=4:
  - After training, `busy`=1 and `learning_enable`=0 for 4 cycles.
  - `cmd_ready`=1 on cycle 13.
